// File: rtl/conv5x5_mac.sv
// 5x5 signed convolution MAC: serial coefficient load, 4-stage multiply/reduce/shift/saturate pipe.
// Optional macro CONV5X5_RELU_EN clamps negative results to zero before saturation.
module conv5x5_mac #(
  parameter int unsigned PIX_BITS = 8,
  parameter int unsigned WT_BITS  = 8,
  parameter int unsigned ACC_BITS = 24,
  parameter int unsigned OUT_BITS = 8,
  parameter int unsigned SHIFT    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wt_valid,
  input  logic [WT_BITS-1:0]  wt_data,
  output logic                wt_ready,
  input  logic                valid_in,
  input  logic [PIX_BITS-1:0] w00, w01, w02, w03, w04,
  input  logic [PIX_BITS-1:0] w10, w11, w12, w13, w14,
  input  logic [PIX_BITS-1:0] w20, w21, w22, w23, w24,
  input  logic [PIX_BITS-1:0] w30, w31, w32, w33, w34,
  input  logic [PIX_BITS-1:0] w40, w41, w42, w43, w44,
  output logic                valid_out,
  output logic [OUT_BITS-1:0] pix_out,
  output logic                drop_flag
);

  localparam int unsigned ProdBits = PIX_BITS + WT_BITS;
  localparam logic signed [ACC_BITS-1:0] OutMax = ACC_BITS'((2 ** (OUT_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] OutMin = ~OutMax;

  typedef enum logic {StLoad, StReady} state_e;

  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] wr_idx;
  logic       accept;

  logic signed [PIX_BITS-1:0] win [25];
  logic signed [WT_BITS-1:0]  k_q [25];
  logic signed [WT_BITS-1:0]  bias_q;

  logic signed [ProdBits-1:0] prod_q [25];
  logic signed [ACC_BITS-1:0] row_d [5];
  logic signed [ACC_BITS-1:0] row_q [5];
  logic signed [ACC_BITS-1:0] acc_d, acc_q;
  logic signed [ACC_BITS-1:0] shifted, relu_d;
  logic [OUT_BITS-1:0]        sat_d;
  logic                       v1_q, v2_q, v3_q;

  assign win[0]  = w00; assign win[1]  = w01; assign win[2]  = w02;
  assign win[3]  = w03; assign win[4]  = w04; assign win[5]  = w10;
  assign win[6]  = w11; assign win[7]  = w12; assign win[8]  = w13;
  assign win[9]  = w14; assign win[10] = w20; assign win[11] = w21;
  assign win[12] = w22; assign win[13] = w23; assign win[14] = w24;
  assign win[15] = w30; assign win[16] = w31; assign win[17] = w32;
  assign win[18] = w33; assign win[19] = w34; assign win[20] = w40;
  assign win[21] = w41; assign win[22] = w42; assign win[23] = w43;
  assign win[24] = w44;

  // Load FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Load FSM: next state; a word arriving in READY restarts the load at index 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StLoad: begin
        if (wt_valid) begin
          if (cnt_q == 5'd25) begin
            state_d = StReady;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StReady: begin
        if (wt_valid) begin
          state_d = StLoad;
          cnt_d   = 5'd1;
        end
      end
    endcase
  end

  // Load FSM: outputs
  always_comb begin
    wt_ready = (state_q == StReady);
    wr_idx   = (state_q == StReady) ? 5'd0 : cnt_q;
  end

  assign accept = valid_in && wt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 25; i++) k_q[i] <= '0;
      bias_q <= '0;
    end else if (wt_valid) begin
      for (int i = 0; i < 25; i++) begin
        if (wr_idx == 5'(i)) k_q[i] <= wt_data;
      end
      if (wr_idx == 5'd25) bias_q <= wt_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_flag <= 1'b0;
    else if (valid_in && !wt_ready) drop_flag <= 1'b1;
  end

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      row_d[r] = '0;
      for (int c = 0; c < 5; c++) row_d[r] = row_d[r] + ACC_BITS'(prod_q[r * 5 + c]);
    end
    acc_d = ACC_BITS'(bias_q);
    for (int r = 0; r < 5; r++) acc_d = acc_d + row_q[r];
  end

  // Arithmetic shift floors toward minus infinity
  always_comb begin
    shifted = acc_q >>> SHIFT;
`ifdef CONV5X5_RELU_EN
    relu_d = shifted[ACC_BITS-1] ? '0 : shifted;
`else
    relu_d = shifted;
`endif
    if (relu_d > OutMax)      sat_d = OutMax[OUT_BITS-1:0];
    else if (relu_d < OutMin) sat_d = OutMin[OUT_BITS-1:0];
    else                      sat_d = relu_d[OUT_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      valid_out <= 1'b0;
      pix_out   <= '0;
      acc_q     <= '0;
      for (int i = 0; i < 25; i++) prod_q[i] <= '0;
      for (int r = 0; r < 5; r++) row_q[r] <= '0;
    end else begin
      v1_q      <= accept;
      v2_q      <= v1_q;
      v3_q      <= v2_q;
      valid_out <= v3_q;
      if (accept) begin
        for (int i = 0; i < 25; i++) prod_q[i] <= ProdBits'(win[i]) * ProdBits'(k_q[i]);
      end
      if (v1_q) begin
        for (int r = 0; r < 5; r++) row_q[r] <= row_d[r];
      end
      if (v2_q) acc_q <= acc_d;
      if (v3_q) pix_out <= sat_d;
    end
  end

endmodule

// File: tb/tb_conv5x5_mac.sv
// Randomised bench for conv5x5_mac: two instances (SHIFT=7 and SHIFT=0) against an arithmetic model.
module tb_conv5x5_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       wt_valid = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] wt_data = '0;
  logic [7:0] wv [25];

  logic              ready_a, ready_b, vout_a, vout_b, drop_a, drop_b;
  logic signed [7:0] pix_a, pix_b;

  typedef struct {
    int due;
    int p7;
    int p0;
  } exp_t;

  exp_t q[$];
  int   cyc = 0, n_vec = 0, n_err = 0;
  int   m_k[25], m_bias = 0, m_cnt = 0;
  bit   m_ready = 0, m_drop = 0;
  int   ld_k[25], ld_b = 0;
  int   last7 = 0, last0 = 0;

  conv5x5_mac #(.SHIFT(7)) dut_a (
    .clk(clk), .rst_n(rst_n), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(ready_a),
    .valid_in(valid_in),
    .w00(wv[0]),  .w01(wv[1]),  .w02(wv[2]),  .w03(wv[3]),  .w04(wv[4]),
    .w10(wv[5]),  .w11(wv[6]),  .w12(wv[7]),  .w13(wv[8]),  .w14(wv[9]),
    .w20(wv[10]), .w21(wv[11]), .w22(wv[12]), .w23(wv[13]), .w24(wv[14]),
    .w30(wv[15]), .w31(wv[16]), .w32(wv[17]), .w33(wv[18]), .w34(wv[19]),
    .w40(wv[20]), .w41(wv[21]), .w42(wv[22]), .w43(wv[23]), .w44(wv[24]),
    .valid_out(vout_a), .pix_out(pix_a), .drop_flag(drop_a)
  );

  conv5x5_mac #(.SHIFT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(ready_b),
    .valid_in(valid_in),
    .w00(wv[0]),  .w01(wv[1]),  .w02(wv[2]),  .w03(wv[3]),  .w04(wv[4]),
    .w10(wv[5]),  .w11(wv[6]),  .w12(wv[7]),  .w13(wv[8]),  .w14(wv[9]),
    .w20(wv[10]), .w21(wv[11]), .w22(wv[12]), .w23(wv[13]), .w24(wv[14]),
    .w30(wv[15]), .w31(wv[16]), .w32(wv[17]), .w33(wv[18]), .w34(wv[19]),
    .w40(wv[20]), .w41(wv[21]), .w42(wv[22]), .w43(wv[23]), .w44(wv[24]),
    .valid_out(vout_b), .pix_out(pix_b), .drop_flag(drop_b)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Convolution straight from the definition: dot product + bias, floor shift, clamp
  function automatic int ref_pix(input int sh);
    longint acc;
    acc = m_bias;
    for (int i = 0; i < 25; i++) acc += longint'($signed(wv[i])) * m_k[i];
    acc = acc >>> sh;
`ifdef CONV5X5_RELU_EN
    if (acc < 0) acc = 0;
`endif
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return int'(acc);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 25; i++) m_k[i] = 0;
    m_bias = 0; m_cnt = 0; m_ready = 0; m_drop = 0;
    last7 = 0; last0 = 0;
  endtask

  task automatic tick();
    exp_t e;
    bit   exp_v;
    if (rst_n && valid_in && m_ready) begin
      e.due = cyc + 4; e.p7 = ref_pix(7); e.p0 = ref_pix(0);
      q.push_back(e);
    end
    if (rst_n && valid_in && !m_ready) m_drop = 1;
    if (rst_n && wt_valid) begin
      if (m_ready) begin
        m_k[0] = int'($signed(wt_data)); m_cnt = 1; m_ready = 0;
      end else if (m_cnt == 25) begin
        m_bias = int'($signed(wt_data)); m_cnt = 0; m_ready = 1;
      end else begin
        m_k[m_cnt] = int'($signed(wt_data)); m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    exp_v = 0;
    if (q.size() > 0) begin
      if (q[0].due == cyc) begin
        exp_v = 1; last7 = q[0].p7; last0 = q[0].p0;
        void'(q.pop_front());
      end
    end
    check("valid_s7", vout_a, exp_v);
    check("pix_s7", pix_a, last7);
    check("valid_s0", vout_b, exp_v);
    check("pix_s0", pix_b, last0);
    check("wt_ready", ready_a, m_ready);
    check("drop_flag", drop_a, m_drop);
  endtask

  task automatic load_range(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      wt_valid = 1'b1;
      wt_data  = (i == 25) ? 8'(ld_b) : 8'(ld_k[i]);
      tick();
    end
    wt_valid = 1'b0;
  endtask

  task automatic set_window(input int val, input bit rnd);
    for (int i = 0; i < 25; i++) wv[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(val);
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0; wt_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int i = 0; i < 25; i++) begin wv[i] = '0; m_k[i] = 0; ld_k[i] = 0; end
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", vout_a, 0);
    check("rst_pix", pix_a, 0);
    check("rst_ready", ready_a, 0);
    check("rst_drop", drop_a, 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    // All-ones kernel, zero bias, all-2 window: 50 >> 7 = 0, unshifted 50
    for (int i = 0; i < 25; i++) ld_k[i] = 1;
    ld_b = 0;
    load_range(0, 25);
    set_window(2, 0); valid_in = 1'b1; tick();
    idle(6);

    // Saturation: 127*127*25 high, -128*127*25 low (or zero with ReLU)
    for (int i = 0; i < 25; i++) ld_k[i] = 127;
    load_range(0, 25);
    set_window(127, 0); valid_in = 1'b1; tick();
    idle(5);
    for (int i = 0; i < 25; i++) ld_k[i] = -128;
    load_range(0, 25);
    set_window(127, 0); valid_in = 1'b1; tick();
    idle(5);

    // Window during a partial load is dropped; next window after the load is processed
    for (int i = 0; i < 25; i++) ld_k[i] = $urandom_range(0, 255) - 128;
    ld_b = $urandom_range(0, 255) - 128;
    load_range(0, 9);
    set_window(0, 1); valid_in = 1'b1; tick(); valid_in = 1'b0;
    load_range(10, 25);
    set_window(0, 1); valid_in = 1'b1; tick();
    idle(5);

    // Window and coefficient word on the same edge uses old weights; next window is dropped
    for (int i = 0; i < 25; i++) ld_k[i] = $urandom_range(0, 255) - 128;
    ld_b = $urandom_range(0, 255) - 128;
    set_window(0, 1); valid_in = 1'b1; wt_valid = 1'b1; wt_data = 8'(ld_k[0]); tick();
    wt_valid = 1'b0; set_window(0, 1); tick();
    valid_in = 1'b0;
    load_range(1, 25);
    idle(5);

    // Eight back-to-back windows
    for (int n = 0; n < 8; n++) begin set_window(0, 1); valid_in = 1'b1; tick(); end
    idle(6);

    // Random rounds: fresh coefficients, windows arriving at random during and after the load
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 25; i++) ld_k[i] = $urandom_range(0, 255) - 128;
      ld_b = $urandom_range(0, 255) - 128;
      for (int i = 0; i <= 25; i++) begin
        wt_valid = 1'b1;
        wt_data  = (i == 25) ? 8'(ld_b) : 8'(ld_k[i]);
        valid_in = ($urandom_range(0, 7) == 0);
        set_window(0, 1);
        tick();
      end
      wt_valid = 1'b0;
      for (int n = 0; n < 16; n++) begin
        valid_in = ($urandom_range(0, 1) == 1);
        set_window(0, 1);
        tick();
      end
      idle(5);
    end

    // Reset with three results in flight: outputs clear at once, nothing emerges afterwards
    for (int n = 0; n < 3; n++) begin set_window(0, 1); valid_in = 1'b1; tick(); end
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", vout_a, 0);
    check("midrst_pix", pix_a, 0);
    check("midrst_ready", ready_a, 0);
    check("midrst_drop", drop_a, 0);
    model_reset();
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    idle(10);
    load_range(0, 25);
    set_window(0, 1); valid_in = 1'b1; tick();
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
